mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store initiator between the MIPS MEM stage and the word-organised data RAM.
//  Accepts byte/halfword/word loads and stores, then drives the RAM's address, write_en, read_en and data_write.
//  Sub-word stores use read-modify-write; loads are extracted from the word and sign/zero-extended.
//  Misaligned and out-of-range accesses are reported without touching the RAM.
// PARAMETERS
//  MEM_WORDS   32   RAM depth in 32-bit words; word index = addr>>2 must be < MEM_WORDS
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   asynchronous, active-high reset
//  req_valid      in   1   MEM-stage request present
//  req_ready      out  1   unit can accept a request this cycle
//  req_we         in   1   1=store, 0=load
//  req_size       in   2   00=byte, 01=half, 10=word, 11=illegal (error)
//  req_signed     in   1   loads only: 1=sign-extend, 0=zero-extend
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-justified for byte/half
//  resp_valid     out  1   one-cycle pulse: request complete
//  resp_rdata     out  32  load result (0 for stores and errors), valid with resp_valid
//  resp_err       out  1   misaligned/illegal-size/out-of-range, valid with resp_valid
//  ram_address    out  32  byte address to RAM, always word-aligned (addr & ~3)
//  ram_data_write out  32  word to write
//  ram_write_en   out  1   RAM write strobe
//  ram_read_en    out  1   RAM read enable
//  ram_data_out   in   32  RAM combinational read data (X when ram_read_en=0)
// BEHAVIOUR
//  Reset: state=INIT; req_ready, resp_valid, resp_err, ram_write_en, ram_read_en=0;
//   resp_rdata, ram_address, ram_data_write=0; latched request cleared.
//  Byte lanes are little-endian: byte k = bits[8k+7:8k]; half h = bits[16h+15:16h].
//  FSM states:
//   INIT: one cycle after reset release with req_ready=0, covering the RAM's first-cycle write blanking; -> IDLE.
//   IDLE: req_ready=1. On req_valid, latch addr/size/we/signed/wdata.
//    Error check is performed here, and the first matching case applies:
//     1. size=11
//     2. half with addr[0]=1
//     3. word with addr[1:0]!=0
//     4. (addr>>2)>=MEM_WORDS
//    On error, go to RESP with err=1.
//    Otherwise go to LOAD for a load, STORE for a word store, or RMW_RD for a byte/half store.
//   LOAD: ram_read_en=1; at clock edge register extracted and extended ram_data_out into resp_rdata; -> RESP.
//   RMW_RD: ram_read_en=1; at edge register ram_data_out with target lane(s) replaced by req_wdata[7:0]/[15:0]; -> STORE.
//   STORE: ram_write_en=1, ram_data_write=merged word (word store: req_wdata); -> RESP.
//   RESP: resp_valid=1 for exactly one cycle, req_ready=0; -> IDLE.
//  Latency from accept edge to resp_valid:
//   error: 1 cycle; load: 2 cycles; word store: 2 cycles; byte/half store: 3 cycles.
//  ram_read_en and ram_write_en are never high together; neither is high outside LOAD/RMW_RD/STORE.
//  ram_data_out is sampled only in LOAD/RMW_RD.
//  req_ready is high only in IDLE; req_valid in any other state is ignored (not queued).
//  resp_rdata holds its last value between responses; it is forced to 0 on store and error responses.
//  Reset asserted mid-operation aborts immediately to INIT with all strobes low.
//   A store in RMW_RD is abandoned with no write; a write already strobed in STORE may or may not commit.
//  Address wrap: none. Out-of-range check uses the full 32-bit address; 0xFFFFFFFC is out of range.
// TESTING
//  reset then req_valid same cycle as release -> req_ready=0 in INIT, accepted one cycle later, no RAM strobe in INIT.
//  store word 0xDEADBEEF @0x8 then load word @0x8 -> ram_write_en 1 cycle with ram_address=0x8; resp_rdata=0xDEADBEEF, err=0, 2-cycle latency.
//  word@0x4=0x11223344; store byte 0xAA @0x6 -> RMW writes 0x11AA3344; load byte signed @0x6 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
//  load half signed @0x2 of 0x80010000 -> 0xFFFF8001; store half @0x1 -> resp_err=1 after 1 cycle, no RAM strobes.
//  load word @ (MEM_WORDS*4) -> resp_err=1, resp_rdata=0; load word @0x7C (MEM_WORDS=32) -> err=0.
//  reset asserted during RMW_RD of byte store -> strobes drop immediately, memory word unchanged, next req after INIT.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MIPS MEM stage and a word-organised data RAM.
// Sub-word stores are read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_write,
    output logic        ram_write_en,
    output logic        ram_read_en,
    input  logic [31:0] ram_data_out
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_STORE,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t      r_state;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [15:0] r_wdata;

    logic [31:0] w_word_idx;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Range check uses the full address: no wrap, so high addresses stay out of range.
    assign w_word_idx = {2'b00, req_addr[31:2]};

    always_comb begin
        w_err = 1'b0;
        if (req_size == SZ_BAD)
            w_err = 1'b1;
        else if (req_size == SZ_HALF && req_addr[0])
            w_err = 1'b1;
        else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            w_err = 1'b1;
        else if (w_word_idx >= 32'(MEM_WORDS))
            w_err = 1'b1;
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = ram_data_out[7:0];
            2'd1:    w_byte = ram_data_out[15:8];
            2'd2:    w_byte = ram_data_out[23:16];
            default: w_byte = ram_data_out[31:24];
        endcase
        w_half = r_lane[1] ? ram_data_out[31:16] : ram_data_out[15:0];
    end

    always_comb begin
        w_load = ram_data_out;
        case (r_size)
            SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = ram_data_out;
        endcase
    end

    always_comb begin
        w_merged = ram_data_out;
        case (r_size)
            SZ_BYTE: w_merged[{r_lane, 3'b000} +: 8]        = r_wdata[7:0];
            SZ_HALF: w_merged[{r_lane[1], 4'b0000} +: 16]   = r_wdata;
            default: w_merged = ram_data_out;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_INIT;
            r_lane         <= '0;
            r_size         <= '0;
            r_signed       <= 1'b0;
            r_wdata        <= '0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            ram_address    <= '0;
            ram_data_write <= '0;
            ram_write_en   <= 1'b0;
            ram_read_en    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end

                S_IDLE: begin
                    if (req_valid) begin
                        r_lane    <= req_addr[1:0];
                        r_size    <= req_size;
                        r_signed  <= req_signed;
                        r_wdata   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        if (w_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            r_state    <= S_RESP;
                        end else if (!req_we) begin
                            ram_address <= {req_addr[31:2], 2'b00};
                            ram_read_en <= 1'b1;
                            r_state     <= S_LOAD;
                        end else if (req_size == SZ_WORD) begin
                            ram_address    <= {req_addr[31:2], 2'b00};
                            ram_data_write <= req_wdata;
                            ram_write_en   <= 1'b1;
                            r_state        <= S_STORE;
                        end else begin
                            ram_address <= {req_addr[31:2], 2'b00};
                            ram_read_en <= 1'b1;
                            r_state     <= S_RMW_RD;
                        end
                    end
                end

                S_LOAD: begin
                    ram_read_en <= 1'b0;
                    resp_valid  <= 1'b1;
                    resp_err    <= 1'b0;
                    resp_rdata  <= w_load;
                    r_state     <= S_RESP;
                end

                S_RMW_RD: begin
                    ram_read_en    <= 1'b0;
                    ram_write_en   <= 1'b1;
                    ram_data_write <= w_merged;
                    r_state        <= S_STORE;
                end

                S_STORE: begin
                    ram_write_en <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_err     <= 1'b0;
                    resp_rdata   <= '0;
                    r_state      <= S_RESP;
                end

                S_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end

                default: begin
                    req_ready    <= 1'b0;
                    resp_valid   <= 1'b0;
                    resp_err     <= 1'b0;
                    ram_write_en <= 1'b0;
                    ram_read_en  <= 1'b0;
                    r_state      <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec vectors plus random traffic checked
// against a byte-addressed reference memory.
module tb_mem_access_unit;

    localparam int MEM_WORDS = 32;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_address;
    logic [31:0] ram_data_write;
    logic        ram_write_en;
    logic        ram_read_en;
    logic [31:0] ram_data_out;

    mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ram_address    (ram_address),
        .ram_data_write (ram_data_write),
        .ram_write_en   (ram_write_en),
        .ram_read_en    (ram_read_en),
        .ram_data_out   (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM attached to the DUT, combinational read.
    logic [31:0] ram [MEM_WORDS] = '{default: 32'h0};
    logic [31:0] ram_idx;
    assign ram_idx = ram_address >> 2;
    assign ram_data_out = (ram_read_en && ram_idx < 32'(MEM_WORDS)) ? ram[ram_idx[4:0]] : 'x;
    always @(posedge clk)
        if (ram_write_en && ram_idx < 32'(MEM_WORDS))
            ram[ram_idx[4:0]] <= ram_data_write;

    // Reference memory, byte addressed.
    logic [7:0] refb [MEM_WORDS*4];

    int n_cmp = 0;
    int n_bad = 0;

    int          lat_got, n_we, n_re;
    logic [31:0] we_addr, we_data, got_rdata;
    logic        got_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("rw_exclusive", 32'(ram_read_en & ram_write_en), 32'd0);
            check("ram_aligned", 32'(ram_address[1:0]), 32'd0);
            check("strobe_outside_access", 32'((req_ready | resp_valid) & (ram_read_en | ram_write_en)), 32'd0);
        end
    end

    function automatic logic [31:0] ref_word(input int unsigned w);
        logic [31:0] v;
        v = '0;
        for (int unsigned i = 0; i < 4; i++)
            v = v | (32'(refb[w*4 + i]) << (8*i));
        return v;
    endfunction

    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd, output int lat);
        int unsigned nb;
        logic [63:0] v;
        nb = 1 << sz;
        e  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
             || (a / 4 >= 32'(MEM_WORDS));
        rd = '0;
        if (e) begin
            lat = 1;
        end else if (we) begin
            for (int unsigned i = 0; i < nb; i++)
                refb[a + i] = 8'(wd >> (8*i));
            lat = (nb == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int unsigned i = 0; i < nb; i++)
                v = v | (64'(refb[a + i]) << (8*i));
            if (sg && v[8*nb-1])
                v = v | ~((64'd1 << (8*nb)) - 64'd1);
            rd  = v[31:0];
            lat = 2;
        end
    endtask

    task automatic start_req(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        lat_got = 0;
        n_we    = 0;
        n_re    = 0;
        we_addr = '0;
        we_data = '0;
        while (1) begin
            @(negedge clk);
            lat_got++;
            if (ram_write_en) begin
                n_we++;
                we_addr = ram_address;
                we_data = ram_data_write;
            end
            if (ram_read_en) n_re++;
            if (resp_valid || lat_got >= 8) break;
        end
        check("resp_timeout", 32'(resp_valid), 32'd1);
        got_rdata = resp_rdata;
        got_err   = resp_err;
    endtask

    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        logic [31:0] rd;
        int          lat;
        model(we, sz, sg, a, wd, e, rd, lat);
        start_req(we, sz, sg, a, wd);
        wait_resp();
        check("latency", 32'(lat_got), 32'(lat));
        check("resp_err", 32'(got_err), 32'(e));
        check("resp_rdata", got_rdata, rd);
        if (e) begin
            check("err_no_strobe", 32'(n_we + n_re), 32'd0);
        end else if (!we) begin
            check("load_read_cycles", 32'(n_re), 32'd1);
            check("load_write_cycles", 32'(n_we), 32'd0);
        end else begin
            check("store_write_cycles", 32'(n_we), 32'd1);
            check("store_addr", we_addr, a & ~32'd3);
            check("store_read_cycles", 32'(n_re), (sz == 2'd2) ? 32'd0 : 32'd1);
            if (sz == 2'd2) check("store_word_data", we_data, wd);
        end
        @(negedge clk);
        check("resp_single_pulse", 32'(resp_valid), 32'd0);
        check("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        e;
        logic [31:0] rd;
        int          lat;
        logic [31:0] a;
        logic [1:0]  sz;

        for (int unsigned i = 0; i < MEM_WORDS*4; i++) refb[i] = 8'h00;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_strobes", 32'({ram_write_en, ram_read_en}), 32'd0);
        check("rst_ram_addr", ram_address, 32'd0);
        check("rst_ram_wdata", ram_data_write, 32'd0);

        // Request presented in the same cycle reset releases.
        model(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, e, rd, lat);
        reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
        #1;
        check("init_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("init_no_strobe", 32'({ram_write_en, ram_read_en}), 32'd0);
        check("idle_ready_high", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp();
        check("first_latency", 32'(lat_got), 32'd2);
        check("first_rdata", got_rdata, rd);
        check("first_err", 32'(got_err), 32'd0);

        run_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
        check("spec_store_addr", we_addr, 32'h8);
        run_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
        check("spec_load_deadbeef", got_rdata, 32'hDEADBEEF);

        run_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344);
        run_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h000000AA);
        check("spec_rmw_data", we_data, 32'h11AA3344);
        check("spec_rmw_ram", ram[1], 32'h11AA3344);
        run_req(1'b0, 2'd0, 1'b1, 32'h6, 32'h0);
        check("spec_lb_signed", got_rdata, 32'hFFFFFFAA);
        run_req(1'b0, 2'd0, 1'b0, 32'h6, 32'h0);
        check("spec_lb_unsigned", got_rdata, 32'h000000AA);

        run_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h80010000);
        run_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
        check("spec_lh_signed", got_rdata, 32'hFFFF8001);
        run_req(1'b1, 2'd1, 1'b0, 32'h1, 32'h1234);
        check("spec_sh_misaligned", 32'(got_err), 32'd1);

        run_req(1'b0, 2'd2, 1'b0, 32'(MEM_WORDS*4), 32'h0);
        check("spec_oob_err", 32'(got_err), 32'd1);
        run_req(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0);
        check("spec_last_word_ok", 32'(got_err), 32'd0);
        run_req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0);
        run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        run_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h55);

        // Reset during the read half of a byte store must abandon it.
        run_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D);
        start_req(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000005A);
        @(negedge clk);
        check("rmw_read_phase", 32'(ram_read_en), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_strobes", 32'({ram_write_en, ram_read_en}), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_resp", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_init_ready", 32'(req_ready), 32'd0);
        check("abort_ram_unchanged", ram[5], 32'hCAFEF00D);
        run_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        check("abort_load_back", got_rdata, 32'hCAFEF00D);

        for (int unsigned n = 0; n < 160; n++) begin
            if ($urandom_range(0, 7) == 0)
                a = $urandom;
            else
                a = 32'($urandom_range(0, MEM_WORDS*4 + 15));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            run_req(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        for (int unsigned w = 0; w < MEM_WORDS; w++)
            check("final_mem", ram[w], ref_word(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
